// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state type and default widths for the PWM capture block
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } cap_state_e;

  localparam int CNT_W_DEF  = 24;
  localparam int DUTY_W_DEF = 7;

  localparam logic [CNT_W_DEF-1:0] TIMEOUT = '1;

endpackage

// File: rtl/pwm_duty_div.sv
// rtl/pwm_duty_div.sv - restoring divider producing floor(high*2^DUTY_W/period), one bit per cycle
// Relies on high < period, so the partial remainder always fits in CNT_W bits.
module pwm_duty_div
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  high,
  input  logic [CNT_W-1:0]  period,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  localparam int IT_W = $clog2(DUTY_W);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(DUTY_W - 1);

  logic              busy_q, busy_d;
  logic [IT_W-1:0]   it_q, it_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [DUTY_W-2:0] quo_q, quo_d;
  logic [CNT_W:0]    trial;
  logic              take;

  always_comb begin
    trial  = {rem_q, 1'b0};
    take   = (trial >= {1'b0, dvs_q});
    busy_d = busy_q;
    it_d   = it_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    if (busy_q) begin
      rem_d = take ? CNT_W'(trial - {1'b0, dvs_q}) : trial[CNT_W-1:0];
      quo_d = {quo_q[DUTY_W-3:0], take};
      it_d  = it_q + 1'b1;
      if (it_q == LAST_IT) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      rem_d  = high;
      dvs_d  = period;
      quo_d  = '0;
      it_d   = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      it_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      it_q   <= it_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
    end
  end

  // The final quotient bit is resolved combinationally in the last iteration cycle.
  assign busy     = busy_q;
  assign done     = busy_q && (it_q == LAST_IT);
  assign quotient = {quo_q, take};

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period, high time and duty of an asynchronous PWM input
// Edges are timed rise-to-rise; each completed period is handed to the duty divider if it is free.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic [DUTY_W-1:0] duty_out,
  output logic              valid,
  output logic              overrun,
  output logic              no_signal
);

  localparam logic [CNT_W-1:0] CNT_MAX = (CNT_W <= CNT_W_DEF) ? CNT_W'(TIMEOUT) : '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cap_state_e        state_q, state_d;
  logic [2:0]        s_q, s_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0]  cap_per_q, cap_per_d;
  logic [CNT_W-1:0]  cap_hi_q, cap_hi_d;
  logic              tmo_pend_q, tmo_pend_d;
  logic [CNT_W-1:0]  period_out_q, period_out_d;
  logic [CNT_W-1:0]  high_out_q, high_out_d;
  logic [DUTY_W-1:0] duty_out_q, duty_out_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              no_signal_q, no_signal_d;

  logic              rise, fall;
  logic [CNT_W-1:0]  per_inc, hi_inc;
  logic              div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;

  assign rise    = s_q[1] & ~s_q[2];
  assign fall    = ~s_q[1] & s_q[2];
  assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
  assign hi_inc  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_ONE;

  pwm_duty_div #(
    .CNT_W (CNT_W),
    .DUTY_W(DUTY_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .high    (hi_lat_q),
    .period  (per_cnt_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );

  always_comb begin
    s_d          = {s_q[1:0], pwm_in};
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    hi_lat_d     = hi_lat_q;
    cap_per_d    = cap_per_q;
    cap_hi_d     = cap_hi_q;
    tmo_pend_d   = tmo_pend_q;
    div_start    = 1'b0;
    period_out_d = period_out_q;
    high_out_d   = high_out_q;
    duty_out_d   = duty_out_q;
    valid_d      = 1'b0;
    overrun_d    = 1'b0;
    no_signal_d  = no_signal_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = HIGH;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
        end
      end
      HIGH: begin
        if (per_cnt_q == CNT_MAX) begin
          state_d    = IDLE;
          tmo_pend_d = 1'b1;
        end else begin
          per_cnt_d = per_inc;
          hi_cnt_d  = hi_inc;
          if (fall) begin
            state_d  = LOW;
            hi_lat_d = hi_cnt_q;
          end
        end
      end
      LOW: begin
        if (per_cnt_q == CNT_MAX) begin
          state_d    = IDLE;
          tmo_pend_d = 1'b1;
        end else if (rise) begin
          // A dropped period still restarts timing so the next one is measured cleanly.
          if (!div_busy) begin
            div_start = 1'b1;
            cap_per_d = per_cnt_q;
            cap_hi_d  = hi_lat_q;
          end else begin
            overrun_d = 1'b1;
          end
          state_d   = HIGH;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (div_done) begin
      period_out_d = cap_per_q;
      high_out_d   = cap_hi_q;
      duty_out_d   = div_quot;
      no_signal_d  = 1'b0;
      valid_d      = 1'b1;
    end else if (tmo_pend_q && !div_busy) begin
      period_out_d = '0;
      high_out_d   = '0;
      duty_out_d   = s_q[2] ? '1 : '0;
      no_signal_d  = 1'b1;
      valid_d      = 1'b1;
      tmo_pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      hi_lat_q     <= '0;
      cap_per_q    <= '0;
      cap_hi_q     <= '0;
      tmo_pend_q   <= 1'b0;
      period_out_q <= '0;
      high_out_q   <= '0;
      duty_out_q   <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      hi_lat_q     <= hi_lat_d;
      cap_per_q    <= cap_per_d;
      cap_hi_q     <= cap_hi_d;
      tmo_pend_q   <= tmo_pend_d;
      period_out_q <= period_out_d;
      high_out_q   <= high_out_d;
      duty_out_q   <= duty_out_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign period_out = period_out_q;
  assign high_out   = high_out_q;
  assign duty_out   = duty_out_q;
  assign valid      = valid_q;
  assign overrun    = overrun_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int CNT_W  = 10;
  localparam int DUTY_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pwm_in = 1'b0;
  logic [CNT_W-1:0]  period_out;
  logic [CNT_W-1:0]  high_out;
  logic [DUTY_W-1:0] duty_out;
  logic              valid;
  logic              overrun;
  logic              no_signal;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  int last_per = 0;
  int last_hi = 0;
  int last_duty = 0;
  int duty_log[$];

  int tp_per[3]  = '{128, 256, 256};
  int tp_hi[3]   = '{64, 1, 255};
  int tp_duty[3] = '{64, 0, 127};

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_W (CNT_W),
    .DUTY_W(DUTY_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .duty_out  (duty_out),
    .valid     (valid),
    .overrun   (overrun),
    .no_signal (no_signal)
  );

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      last_per  = int'(period_out);
      last_hi   = int'(high_out);
      last_duty = int'(duty_out);
      duty_log.push_back(int'(duty_out));
    end
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (valid && overrun) both_cnt = both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    pwm_in = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);
    valid_cnt = 0;
    ovr_cnt   = 0;
    both_cnt  = 0;
    duty_log.delete();
  endtask

  task automatic run_pwm(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      idle(hi);
      pwm_in = 1'b0;
      idle(per - hi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++; if (period_out !== 0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_out); end
    checks++; if (high_out !== 0) begin errors++; $display("FAIL reset_high: got %0d expected 0", high_out); end
    checks++; if (duty_out !== 0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL reset_no_signal: got %0b expected 1", no_signal); end
  endtask

  task automatic test_latency();
    int seen;
    do_reset();
    run_pwm(10, 3, 1);
    pwm_in = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) pwm_in = 1'b0;
      if (valid && seen == 0) seen = k;
    end
    checks++; if (seen != 10) begin errors++; $display("FAIL latency: got %0d expected 10 cycles", seen); end
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL latency_count: got %0d expected 1", valid_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    run_pwm(10, 3, 5);
    idle(20);
    checks++; if (valid_cnt != 4) begin errors++; $display("FAIL basic_valids: got %0d expected 4", valid_cnt); end
    checks++; if (last_per != 10) begin errors++; $display("FAIL basic_period: got %0d expected 10", last_per); end
    checks++; if (last_hi != 3) begin errors++; $display("FAIL basic_high: got %0d expected 3", last_hi); end
    checks++; if (last_duty != 38) begin errors++; $display("FAIL basic_duty: got %0d expected 38", last_duty); end
    checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL basic_no_signal: got %0b expected 0", no_signal); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL basic_overrun: got %0d expected 0", ovr_cnt); end
  endtask

  task automatic test_duty_points();
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_pwm(tp_per[i], tp_hi[i], 3);
      idle(20);
      checks++; if (valid_cnt != 2) begin errors++; $display("FAIL duty_pt%0d_valids: got %0d expected 2", i, valid_cnt); end
      checks++; if (last_per != tp_per[i]) begin errors++; $display("FAIL duty_pt%0d_period: got %0d expected %0d", i, last_per, tp_per[i]); end
      checks++; if (last_hi != tp_hi[i]) begin errors++; $display("FAIL duty_pt%0d_high: got %0d expected %0d", i, last_hi, tp_hi[i]); end
      checks++; if (last_duty != tp_duty[i]) begin errors++; $display("FAIL duty_pt%0d_duty: got %0d expected %0d", i, last_duty, tp_duty[i]); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    run_pwm(4, 2, 10);
    idle(20);
    checks++; if (valid_cnt != 5) begin errors++; $display("FAIL ovr_valids: got %0d expected 5", valid_cnt); end
    checks++; if (ovr_cnt != 4) begin errors++; $display("FAIL ovr_overruns: got %0d expected 4", ovr_cnt); end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL ovr_coincident: got %0d expected 0", both_cnt); end
    checks++; if (last_per != 4) begin errors++; $display("FAIL ovr_period: got %0d expected 4", last_per); end
    checks++; if (last_duty != 64) begin errors++; $display("FAIL ovr_duty: got %0d expected 64", last_duty); end
  endtask

  task automatic test_timeout();
    int c0;
    do_reset();
    run_pwm(10, 3, 3);
    pwm_in = 1'b1;
    idle(30);
    checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL tmo_pre_no_signal: got %0b expected 0", no_signal); end
    c0 = valid_cnt;
    idle(1100);
    checks++; if (valid_cnt - c0 != 1) begin errors++; $display("FAIL tmo_hi_valids: got %0d expected 1", valid_cnt - c0); end
    checks++; if (last_per != 0) begin errors++; $display("FAIL tmo_hi_period: got %0d expected 0", last_per); end
    checks++; if (last_hi != 0) begin errors++; $display("FAIL tmo_hi_high: got %0d expected 0", last_hi); end
    checks++; if (last_duty != 127) begin errors++; $display("FAIL tmo_hi_duty: got %0d expected 127", last_duty); end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL tmo_hi_no_signal: got %0b expected 1", no_signal); end
    idle(300);
    checks++; if (valid_cnt - c0 != 1) begin errors++; $display("FAIL tmo_no_repeat: got %0d expected 1", valid_cnt - c0); end
    pwm_in = 1'b0;
    idle(10);
    pwm_in = 1'b1;
    idle(5);
    pwm_in = 1'b0;
    c0 = valid_cnt;
    idle(1100);
    checks++; if (valid_cnt - c0 != 1) begin errors++; $display("FAIL tmo_lo_valids: got %0d expected 1", valid_cnt - c0); end
    checks++; if (last_per != 0) begin errors++; $display("FAIL tmo_lo_period: got %0d expected 0", last_per); end
    checks++; if (last_duty != 0) begin errors++; $display("FAIL tmo_lo_duty: got %0d expected 0", last_duty); end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL tmo_lo_no_signal: got %0b expected 1", no_signal); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    run_pwm(10, 3, 3);
    pwm_in = 1'b1;
    idle(5);
    checks++; if (period_out !== 10) begin errors++; $display("FAIL rbusy_pre_period: got %0d expected 10", period_out); end
    reset = 1'b0;
    #1;
    checks++; if (period_out !== 0) begin errors++; $display("FAIL rbusy_period: got %0d expected 0", period_out); end
    checks++; if (high_out !== 0) begin errors++; $display("FAIL rbusy_high: got %0d expected 0", high_out); end
    checks++; if (duty_out !== 0) begin errors++; $display("FAIL rbusy_duty: got %0d expected 0", duty_out); end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL rbusy_no_signal: got %0b expected 1", no_signal); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rbusy_valid: got %0b expected 0", valid); end
    pwm_in = 1'b0;
    idle(3);
    reset = 1'b1;
    valid_cnt = 0;
    ovr_cnt   = 0;
    idle(20);
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL rbusy_stale_valid: got %0d expected 0", valid_cnt); end
    run_pwm(20, 5, 2);
    idle(5);
    checks++; if (valid_cnt != 1) begin errors++; $display("FAIL rbusy_resume_valids: got %0d expected 1", valid_cnt); end
    checks++; if (last_per != 20) begin errors++; $display("FAIL rbusy_resume_period: got %0d expected 20", last_per); end
    checks++; if (last_hi != 5) begin errors++; $display("FAIL rbusy_resume_high: got %0d expected 5", last_hi); end
    checks++; if (last_duty != 32) begin errors++; $display("FAIL rbusy_resume_duty: got %0d expected 32", last_duty); end
  endtask

  task automatic test_duty_change();
    int exp_duty[5] = '{32, 32, 32, 96, 96};
    do_reset();
    run_pwm(100, 25, 3);
    run_pwm(100, 75, 3);
    idle(20);
    checks++; if (duty_log.size() != 5) begin errors++; $display("FAIL chg_valids: got %0d expected 5", duty_log.size()); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL chg_overrun: got %0d expected 0", ovr_cnt); end
    if (duty_log.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (duty_log[i] != exp_duty[i]) begin errors++; $display("FAIL chg_duty%0d: got %0d expected %0d", i, duty_log[i], exp_duty[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_duty_points();
    test_overrun();
    test_timeout();
    test_reset_busy();
    test_duty_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
